mux_4x1_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer for a shared 4:1 datapath mux. Four requesters each present a W-bit word and a request line. The block grants one requester at a time, drives the mux select from the grant, and meters words to a single downstream consumer through a valid/ready handshake. Grants are held for bursts of at most MAX_BURST words, so one requester cannot starve the others.

---
 rtl/mux_4x1_rr_arbiter.sv | 122 ++++++++++++
 tb/tb_mux_4x1_rr_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_4x1_rr_arbiter.sv
// Round-robin arbiter and burst sequencer for a shared 4:1 datapath mux.
// One requester owns the mux at a time for up to MAX_BURST beats; each grant
// is followed by a single IDLE cycle in which the next owner is chosen.
module mux_4x1_rr_arbiter #(
  parameter int unsigned W         = 8,
  parameter int unsigned MAX_BURST = 4   // 1..16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     i_req,
  input  logic [4*W-1:0] i_data,
  input  logic           i_out_ready,
  output logic [3:0]     o_gnt,
  output logic [1:0]     o_sel,
  output logic [W-1:0]   o_out_data,
  output logic           o_out_valid,
  output logic [3:0]     o_ack
);

  typedef enum logic {
    StIdle,
    StGrant
  } state_e;

  // Beat count at which the burst is complete (cnt is zero-based).
  localparam logic [3:0] LastCnt = 4'(MAX_BURST - 1);

  state_e     r_state;
  state_e     w_state_d;
  logic [3:0] r_gnt;
  logic [3:0] w_gnt_d;
  logic [1:0] r_sel;
  logic [1:0] w_sel_d;
  logic [1:0] r_ptr;
  logic [1:0] w_ptr_d;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_d;

  logic       w_found;
  logic [1:0] w_pick;
  logic [1:0] w_try;
  logic       w_beat;

  // Round-robin search starting just after the last granted channel; the
  // last granted channel itself is checked last (offset 4 wraps to ptr).
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    w_try   = r_ptr;
    for (int i = 1; i <= 4; i++) begin
      w_try = r_ptr + 2'(i);
      if (!w_found && i_req[w_try]) begin
        w_found = 1'b1;
        w_pick  = w_try;
      end
    end
  end

  // Downstream handshake and the combinational data mux.
  always_comb begin
    o_out_valid = (r_state == StGrant) && i_req[r_sel];
    w_beat      = o_out_valid && i_out_ready;
    o_ack       = r_gnt & {4{w_beat}};
    o_out_data  = i_data[r_sel*W +: W];
  end

  // Next-state logic: arbitrate in IDLE, count beats and release in GRANT.
  always_comb begin
    w_state_d = r_state;
    w_gnt_d   = r_gnt;
    w_sel_d   = r_sel;
    w_ptr_d   = r_ptr;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_state_d = StGrant;
          w_gnt_d   = 4'b0001 << w_pick;
          w_sel_d   = w_pick;
          w_ptr_d   = w_pick;
          w_cnt_d   = '0;
        end
      end
      StGrant: begin
        // Withdrawal ends the grant without a beat; sel is left as-is.
        if (!i_req[r_sel] || (w_beat && (r_cnt == LastCnt))) begin
          w_state_d = StIdle;
          w_gnt_d   = '0;
          w_cnt_d   = '0;
        end else if (w_beat) begin
          w_cnt_d = r_cnt + 4'd1;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_gnt_d   = '0;
        w_cnt_d   = '0;
      end
    endcase
  end

  // State registers; ptr resets to 3 so the first search begins at channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_ptr   <= 2'd3;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_gnt   <= w_gnt_d;
      r_sel   <= w_sel_d;
      r_ptr   <= w_ptr_d;
      r_cnt   <= w_cnt_d;
    end
  end

  assign o_gnt = r_gnt;
  assign o_sel = r_sel;

endmodule

// File: tb/tb_mux_4x1_rr_arbiter.sv
// Self-checking bench for mux_4x1_rr_arbiter: a MAX_BURST=4 instance and a
// MAX_BURST=1 instance share stimulus; expected beats go through a scoreboard.
module tb_mux_4x1_rr_arbiter;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [3:0]     req = 4'b0;
  logic           ready = 1'b0;
  logic           use1 = 1'b0;
  logic [W-1:0]   base [4];
  logic [W-1:0]   adv  [4];
  logic [4*W-1:0] data;

  logic [3:0]   gnt4, ack4, gnt1, ack1;
  logic [1:0]   sel4, sel1;
  logic [W-1:0] odata4, odata1;
  logic         valid4, valid1;

  logic [3:0]   m_gnt, m_ack;
  logic [1:0]   m_sel;
  logic [W-1:0] m_data;
  logic         m_valid;

  typedef struct packed {
    logic [1:0]   ch;
    logic [W-1:0] val;
  } beat_t;
  beat_t sb[$];
  beat_t e;

  int n_pass = 0;
  int n_total = 0;

  mux_4x1_rr_arbiter #(.W(W), .MAX_BURST(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .i_req(req), .i_data(data), .i_out_ready(ready),
    .o_gnt(gnt4), .o_sel(sel4), .o_out_data(odata4), .o_out_valid(valid4), .o_ack(ack4)
  );

  mux_4x1_rr_arbiter #(.W(W), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_req(req), .i_data(data), .i_out_ready(ready),
    .o_gnt(gnt1), .o_sel(sel1), .o_out_data(odata1), .o_out_valid(valid1), .o_ack(ack1)
  );

  always #5 clk = ~clk;

  assign m_gnt   = use1 ? gnt1 : gnt4;
  assign m_ack   = use1 ? ack1 : ack4;
  assign m_sel   = use1 ? sel1 : sel4;
  assign m_data  = use1 ? odata1 : odata4;
  assign m_valid = use1 ? valid1 : valid4;

  // Each requester presents base+adv and advances its word after every ack.
  for (genvar k = 0; k < 4; k++) begin : g_word
    assign data[k*W +: W] = base[k] + adv[k];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) adv[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) if (m_ack[k]) adv[k] <= adv[k] + 1'b1;
    end
  end

  // Monitor: ack rule, sel/gnt agreement, and scoreboard pop on every beat.
  always @(negedge clk) begin
    if (rst_n) begin
      n_total++;
      if (m_ack !== (m_gnt & {4{m_valid & ready}}))
        $display("FAIL ack_rule ack=%b gnt=%b valid=%b ready=%b", m_ack, m_gnt, m_valid, ready);
      else n_pass++;
      if (m_gnt != 4'b0) begin
        n_total++;
        if (m_gnt !== (4'b0001 << m_sel))
          $display("FAIL sel_match sel=%0d gnt=%b", m_sel, m_gnt);
        else n_pass++;
      end
      if (m_ack != 4'b0) begin
        n_total++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_beat ack=%b data=%h expected no beat", m_ack, m_data);
        end else begin
          e = sb.pop_front();
          if ({m_ack, m_sel, m_data} !== {4'b0001 << e.ch, e.ch, e.val})
            $display("FAIL beat ack=%b sel=%0d data=%h expected ch=%0d data=%h",
                     m_ack, m_sel, m_data, e.ch, e.val);
          else n_pass++;
        end
      end
    end
  end

  task automatic do_reset();
    req   = 4'b0;
    ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({gnt4, sel4, valid4, ack4} !== 11'b0 || {gnt1, sel1, valid1, ack1} !== 11'b0)
      $display("FAIL reset_state gnt4=%b sel4=%0d valid4=%b ack4=%b gnt1=%b expected zeros",
               gnt4, sel4, valid4, ack4, gnt1);
    else n_pass++;
    do_reset();
    @(negedge clk);
    n_total++;
    if (gnt4 !== 4'b0 || valid4 !== 1'b0)
      $display("FAIL reset_idle gnt=%b valid=%b expected 0000/0", gnt4, valid4);
    else n_pass++;
  endtask

  task automatic test_single();
    logic [3:0] exp_g;
    use1 = 1'b0;
    do_reset();
    base[0] = 8'h10;
    req = 4'b0001;
    ready = 1'b1;
    for (int i = 0; i < 8; i++) sb.push_back({2'd0, 8'h10 + 8'(i)});
    for (int c = 0; c < 10; c++) begin
      exp_g = (c == 0 || c == 5) ? 4'b0 : 4'b0001;
      @(negedge clk);
      n_total++;
      if (gnt4 !== exp_g || valid4 !== (exp_g != 4'b0))
        $display("FAIL single c=%0d gnt=%b valid=%b expected gnt=%b", c, gnt4, valid4, exp_g);
      else n_pass++;
      @(posedge clk);
      #1;
    end
    req = 4'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if (sb.size() != 0) $display("FAIL single_drain left=%0d expected 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_all_request();
    logic [3:0] exp_g;
    int         ch;
    use1 = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) base[k] = 8'h20 + 8'(16 * k);
    req = 4'b1111;
    ready = 1'b1;
    for (int g = 0; g < 5; g++)
      for (int i = 0; i < 4; i++)
        sb.push_back({2'(g % 4), 8'h20 + 8'(16 * (g % 4)) + 8'(i + 4 * (g / 4))});
    for (int c = 0; c < 25; c++) begin
      ch = ((c - 1) / 5) % 4;
      exp_g = (c == 0 || (c - 1) % 5 == 4) ? 4'b0 : (4'b0001 << ch);
      @(negedge clk);
      n_total++;
      if (gnt4 !== exp_g || (exp_g != 4'b0 && sel4 !== 2'(ch)))
        $display("FAIL all_req c=%0d gnt=%b sel=%0d expected gnt=%b", c, gnt4, sel4, exp_g);
      else n_pass++;
      @(posedge clk);
      #1;
    end
    req = 4'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if (sb.size() != 0) $display("FAIL all_req_drain left=%0d expected 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_g;
    use1 = 1'b0;
    do_reset();
    base[1] = 8'h60;
    req = 4'b0010;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) sb.push_back({2'd1, 8'h60 + 8'(i)});
    for (int c = 0; c < 9; c++) begin
      exp_g = (c == 0 || c == 8) ? 4'b0 : 4'b0010;
      @(negedge clk);
      n_total++;
      if (gnt4 !== exp_g || valid4 !== (exp_g != 4'b0))
        $display("FAIL bp c=%0d gnt=%b valid=%b expected gnt=%b", c, gnt4, valid4, exp_g);
      else n_pass++;
      if (c >= 3 && c <= 5) begin
        n_total++;
        if (ack4 !== 4'b0 || odata4 !== 8'h62)
          $display("FAIL bp_stall c=%0d ack=%b data=%h expected 0000/62", c, ack4, odata4);
        else n_pass++;
      end
      @(posedge clk);
      #1;
      if (c == 2) ready = 1'b0;
      if (c == 5) ready = 1'b1;
      if (c == 7) req = 4'b0;
    end
    n_total++;
    if (sb.size() != 0) $display("FAIL bp_drain left=%0d expected 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_withdraw_skip();
    logic [3:0] exp_g;
    logic       exp_v;
    use1 = 1'b0;
    do_reset();
    base[2] = 8'h70;
    base[3] = 8'h80;
    req = 4'b1100;
    ready = 1'b1;
    sb.push_back({2'd2, 8'h70});
    sb.push_back({2'd2, 8'h71});
    for (int i = 0; i < 4; i++) sb.push_back({2'd3, 8'h80 + 8'(i)});
    for (int i = 0; i < 4; i++) sb.push_back({2'd1, 8'h90 + 8'(i)});
    for (int i = 0; i < 4; i++) sb.push_back({2'd3, 8'h84 + 8'(i)});
    for (int c = 0; c < 19; c++) begin
      if (c >= 1 && c <= 3) exp_g = 4'b0100;
      else if (c >= 5 && c <= 8) exp_g = 4'b1000;
      else if (c >= 10 && c <= 13) exp_g = 4'b0010;
      else if (c >= 15) exp_g = 4'b1000;
      else exp_g = 4'b0;
      exp_v = (exp_g != 4'b0) && (c != 3);
      @(negedge clk);
      n_total++;
      if (gnt4 !== exp_g || valid4 !== exp_v)
        $display("FAIL withdraw c=%0d gnt=%b valid=%b expected gnt=%b valid=%b",
                 c, gnt4, valid4, exp_g, exp_v);
      else n_pass++;
      @(posedge clk);
      #1;
      if (c == 2) req = 4'b1000;
      if (c == 8) begin
        req = 4'b0010;
        base[1] = 8'h90;
      end
      if (c == 9) req = 4'b1010;
      if (c == 18) req = 4'b0;
    end
    n_total++;
    if (sb.size() != 0) $display("FAIL withdraw_drain left=%0d expected 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_async_reset();
    use1 = 1'b0;
    do_reset();
    base[2] = 8'hA0;
    req = 4'b0100;
    ready = 1'b1;
    sb.push_back({2'd2, 8'hA0});
    sb.push_back({2'd2, 8'hA1});
    sb.push_back({2'd0, 8'hB0});
    @(negedge clk);
    @(posedge clk);
    #1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      n_total++;
      if (gnt4 !== 4'b0100 || valid4 !== 1'b1)
        $display("FAIL areset_burst c=%0d gnt=%b valid=%b expected 0100/1", c, gnt4, valid4);
      else n_pass++;
      if (c == 1) begin
        @(posedge clk);
        #1;
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (gnt4 !== 4'b0 || valid4 !== 1'b0 || ack4 !== 4'b0)
      $display("FAIL areset_now gnt=%b valid=%b ack=%b expected 0000/0/0000", gnt4, valid4, ack4);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req = 4'b1111;
    base[0] = 8'hB0;
    @(negedge clk);
    n_total++;
    if (gnt4 !== 4'b0) $display("FAIL areset_idle gnt=%b expected 0000", gnt4);
    else n_pass++;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_total++;
    if (gnt4 !== 4'b0001 || sel4 !== 2'd0)
      $display("FAIL areset_first gnt=%b sel=%0d expected 0001/0", gnt4, sel4);
    else n_pass++;
    @(posedge clk);
    #1;
    req = 4'b0;
    @(negedge clk);
    n_total++;
    if (gnt4 !== 4'b0001 || valid4 !== 1'b0)
      $display("FAIL areset_withdraw gnt=%b valid=%b expected 0001/0", gnt4, valid4);
    else n_pass++;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_total++;
    if (gnt4 !== 4'b0 || sb.size() != 0)
      $display("FAIL areset_end gnt=%b left=%0d expected 0000/0", gnt4, sb.size());
    else n_pass++;
  endtask

  task automatic test_burst_one();
    logic [3:0] exp_g;
    use1 = 1'b1;
    do_reset();
    base[0] = 8'hC0;
    base[1] = 8'hD0;
    req = 4'b0011;
    ready = 1'b1;
    sb.push_back({2'd0, 8'hC0});
    sb.push_back({2'd1, 8'hD0});
    sb.push_back({2'd0, 8'hC1});
    sb.push_back({2'd1, 8'hD1});
    for (int c = 0; c < 8; c++) begin
      if (c % 2 == 0) exp_g = 4'b0;
      else if (c % 4 == 1) exp_g = 4'b0001;
      else exp_g = 4'b0010;
      @(negedge clk);
      n_total++;
      if (gnt1 !== exp_g || valid1 !== (exp_g != 4'b0))
        $display("FAIL burst1 c=%0d gnt=%b valid=%b expected gnt=%b", c, gnt1, valid1, exp_g);
      else n_pass++;
      @(posedge clk);
      #1;
    end
    req = 4'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if (sb.size() != 0) $display("FAIL burst1_drain left=%0d expected 0", sb.size());
    else n_pass++;
    use1 = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) base[k] = '0;
    test_reset();
    test_single();
    test_all_request();
    test_backpressure();
    test_withdraw_skip();
    test_async_reset();
    test_burst_one();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout passed=%0d total=%0d expected completion", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
